sim_mem_port_arbiter: RTL and testbench
=======================================

// Module: sim_mem_port_arbiter
// PURPOSE
//  Shares one behavioural backing-memory read port between N_REQ simulator requesters.
//  Requester order: 0 = icache refill, 1 = dCache miss-read, 2 = dCache uncached read.
//  Sits in the simulation top, between the core tile's memory interfaces and the L2 model.
//  Blocking arbiter: one transaction in flight, round-robin grant.
//  Responses are routed back to the owning requester; a watchdog detects stuck transactions.
// PARAMETERS
//  N_REQ     3     number of requesters (2..4)
//  ADDR_W    40    physical address width
//  DATA_W    128   response beat width
//  ID_W      8     requester transaction-id width
//  TIMEOUT   1024  cycles allowed in ISSUE+WAIT_RESP before abort (>=2)
// PORTS
//  tb_clk          in   1              clock
//  tb_rstn         in   1              async active-low reset
//  req_valid_i     in   N_REQ          per-requester request valid
//  req_ready_o     out  N_REQ          per-requester request accept
//  req_addr_i      in   N_REQ*ADDR_W   packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_id_i        in   N_REQ*ID_W     packed request ids
//  resp_valid_o    out  N_REQ          per-requester response beat valid
//  resp_ready_i    in   N_REQ          per-requester response beat ready
//  resp_data_o     out  DATA_W         response data, broadcast to all requesters
//  resp_id_o       out  ID_W           response id, broadcast
//  resp_last_o     out  1              last beat, broadcast
//  mem_req_valid_o out  1              memory request valid
//  mem_req_ready_i in   1              memory request ready
//  mem_req_addr_o  out  ADDR_W         memory request address
//  mem_req_id_o    out  ID_W+2         memory request id: {src[1:0], id}
//  mem_resp_valid_i in  1              memory response valid
//  mem_resp_ready_o out 1              memory response ready
//  mem_resp_data_i in   DATA_W         memory response data
//  mem_resp_id_i   in   ID_W+2         memory response id
//  mem_resp_last_i in   1              memory response last beat
//  busy_o          out  1              state != IDLE
//  id_err_o        out  1              sticky: response id mismatch seen
//  timeout_o       out  1              sticky: watchdog expired
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; last_grant=N_REQ-1; counters and sticky flags 0.
//  Reset mid-transaction discards the transaction; nothing is replayed.
//  FSM states: IDLE, ISSUE, WAIT_RESP.
//  IDLE:
//   - Winner = first i with req_valid_i[i], scanning (last_grant+1)%N_REQ upward with wrap.
//   - req_ready_o[winner]=1 combinationally in the same cycle; only one bit may be set.
//   - On that cycle latch addr, id and src; -> ISSUE.
//  ISSUE:
//   - mem_req_valid_o=1 from the cycle after accept (1-cycle latency).
//   - addr/id are held stable until mem_req_ready_i; then -> WAIT_RESP.
//  WAIT_RESP:
//   - Matching beat (mem_resp_id_i == latched {src,id}): resp_valid_o[src]=mem_resp_valid_i
//     and mem_resp_ready_o=resp_ready_i[src]. Data/id/last pass through combinationally
//     (0 latency); resp_id_o = low ID_W bits.
//   - Mismatched id: the beat is consumed (mem_resp_ready_o=1), not forwarded, and
//     id_err_o is set.
//   - Handshake on a last beat: -> IDLE and last_grant<=src.
//   - New request accept is possible on the cycle after returning to IDLE.
//  Watchdog:
//   - 16-bit counter, cleared on entering ISSUE, increments each cycle in ISSUE/WAIT_RESP.
//   - When it reaches TIMEOUT: timeout_o<=1, -> IDLE, last_grant<=src.
//   - Late beats arriving afterwards count as mismatches.
//  Simultaneous requests in IDLE: round-robin only. A requester dropping valid before grant
//  is not granted.
//  Starvation bound: a held request is granted within N_REQ-1 transactions.
// CONFIGURATION
//  SIM_MEM_ARB_PERF_EN defined:
//   - Adds output perf_grants_o [N_REQ*32], per-requester 32-bit grant counters.
//   - Counters increment on accept, saturate at 2^32-1, reset to 0.
//   - At end of simulation ($finish via final block) the counters are printed with $display.
//  Not defined: no port, no counters, no display.
// TESTING
//  1 Single icache req addr=0x100 id=3, mem ready immediately, one beat last=1
//    -> mem_req_valid_o cycle+1, mem_req_id_o={2'd0,8'd3}, resp_valid_o=3'b001, busy_o low after.
//  2 All three valid every cycle, 6 transactions -> grant order 0,1,2,0,1,2.
//  3 4-beat response with resp_ready_i[1] low 2 cycles mid-burst
//    -> mem_resp_ready_o low those cycles, no beat lost, IDLE after beat 4.
//  4 Response id {2'd2,8'h5} while {2'd1,8'h5} is outstanding
//    -> beat dropped, id_err_o=1, transaction still completes on the correct id.
//  5 TIMEOUT=16, mem never responds -> timeout_o=1 at cycle 16 after issue, state IDLE,
//    next request granted.
//  6 Reset asserted in WAIT_RESP -> all outputs 0 asynchronously; PERF_EN build shows counters 0.

Source files
------------

// File: rtl/sim_mem_port_arbiter.sv
// Round-robin, single-outstanding arbiter sharing one backing-memory read port between N_REQ
// requesters, with response routing and a stuck-transaction watchdog. SIM_MEM_ARB_PERF_EN adds grant counters.
module sim_mem_port_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned ADDR_W  = 40,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    tb_clk,
    input  logic                    tb_rstn,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*ID_W-1:0]   req_id_i,
    output logic [N_REQ-1:0]        resp_valid_o,
    input  logic [N_REQ-1:0]        resp_ready_i,
    output logic [DATA_W-1:0]       resp_data_o,
    output logic [ID_W-1:0]         resp_id_o,
    output logic                    resp_last_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_W-1:0]       mem_req_addr_o,
    output logic [ID_W+1:0]         mem_req_id_o,
    input  logic                    mem_resp_valid_i,
    output logic                    mem_resp_ready_o,
    input  logic [DATA_W-1:0]       mem_resp_data_i,
    input  logic [ID_W+1:0]         mem_resp_id_i,
    input  logic                    mem_resp_last_i,
    output logic                    busy_o,
    output logic                    id_err_o,
    output logic                    timeout_o
`ifdef SIM_MEM_ARB_PERF_EN
    ,
    output logic [N_REQ*32-1:0]     perf_grants_o
`endif
);

    localparam int unsigned SRC_W = 2;
    localparam int unsigned WD_W  = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               id_err_d, timeout_d;
    logic [SRC_W-1:0]   win, cand;
    logic               win_vld;
    logic               tag_match;
    logic               done;

    assign mem_req_addr_o = addr_q;
    assign mem_req_id_o   = {src_q, id_q};
    assign tag_match      = (mem_resp_id_i == {src_q, id_q});

    // Round-robin pick: first valid requester after the last completed owner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = SRC_W'((32'(last_grant_q) + k) % N_REQ);
            if (!win_vld && req_valid_i[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        src_d            = src_q;
        addr_d           = addr_q;
        id_d             = id_q;
        wd_d             = wd_q;
        id_err_d         = id_err_o;
        timeout_d        = timeout_o;
        done             = 1'b0;
        req_ready_o      = '0;
        resp_valid_o     = '0;
        resp_data_o      = '0;
        resp_id_o        = '0;
        resp_last_o      = 1'b0;
        mem_resp_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Stray beats with nothing outstanding are drained and flagged.
                mem_resp_ready_o = tb_rstn;
                if (mem_resp_valid_i) id_err_d = 1'b1;
                if (win_vld && tb_rstn) begin
                    req_ready_o[win] = 1'b1;
                    src_d            = win;
                    addr_d           = req_addr_i[32'(win)*ADDR_W +: ADDR_W];
                    id_d             = req_id_i[32'(win)*ID_W +: ID_W];
                    wd_d             = '0;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                wd_d             = wd_q + WD_W'(1);
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) id_err_d = 1'b1;
                if (mem_req_ready_i) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                wd_d = wd_q + WD_W'(1);
                if (tag_match) begin
                    resp_valid_o[src_q] = mem_resp_valid_i;
                    mem_resp_ready_o    = resp_ready_i[src_q];
                    resp_data_o         = mem_resp_data_i;
                    resp_id_o           = mem_resp_id_i[ID_W-1:0];
                    resp_last_o         = mem_resp_last_i;
                    done = mem_resp_valid_i && resp_ready_i[src_q] && mem_resp_last_i;
                end else begin
                    mem_resp_ready_o = 1'b1;
                    if (mem_resp_valid_i) id_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A completing last beat wins over a watchdog expiring in the same cycle.
        if (done) begin
            state_d      = IDLE;
            last_grant_d = src_q;
        end else if (state_q != IDLE && wd_q == WD_W'(TIMEOUT - 1)) begin
            timeout_d    = 1'b1;
            state_d      = IDLE;
            last_grant_d = src_q;
        end
    end

    always_ff @(posedge tb_clk or negedge tb_rstn) begin
        if (!tb_rstn) begin
            state_q         <= IDLE;
            last_grant_q    <= SRC_W'(N_REQ - 1);
            src_q           <= '0;
            addr_q          <= '0;
            id_q            <= '0;
            wd_q            <= '0;
            busy_o          <= 1'b0;
            mem_req_valid_o <= 1'b0;
            id_err_o        <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            src_q           <= src_d;
            addr_q          <= addr_d;
            id_q            <= id_d;
            wd_q            <= wd_d;
            busy_o          <= (state_d != IDLE);
            mem_req_valid_o <= (state_d == ISSUE);
            id_err_o        <= id_err_d;
            timeout_o       <= timeout_d;
        end
    end

`ifdef SIM_MEM_ARB_PERF_EN
    logic [31:0] perf_q [N_REQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge tb_clk or negedge tb_rstn) begin
        if (!tb_rstn) begin
            for (int i = 0; i < N_REQ; i++) perf_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready_o[i] && perf_q[i] != '1) perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_perf
        assign perf_grants_o[g*32 +: 32] = perf_q[g];
    end

    final begin
        for (int i = 0; i < N_REQ; i++)
            $display("[sim_mem_port_arbiter] requester %0d grants %0d", i, perf_q[i]);
    end
`endif

endmodule

// File: tb/tb_sim_mem_port_arbiter.sv
// Self-checking bench for sim_mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_sim_mem_port_arbiter;

    localparam int unsigned N_REQ   = 3;
    localparam int unsigned ADDR_W  = 40;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned TIMEOUT = 16;

    logic                    tb_clk;
    logic                    tb_rstn;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ*ADDR_W-1:0] req_addr_i;
    logic [N_REQ*ID_W-1:0]   req_id_i;
    logic [N_REQ-1:0]        resp_valid_o;
    logic [N_REQ-1:0]        resp_ready_i;
    logic [DATA_W-1:0]       resp_data_o;
    logic [ID_W-1:0]         resp_id_o;
    logic                    resp_last_o;
    logic                    mem_req_valid_o;
    logic                    mem_req_ready_i;
    logic [ADDR_W-1:0]       mem_req_addr_o;
    logic [ID_W+1:0]         mem_req_id_o;
    logic                    mem_resp_valid_i;
    logic                    mem_resp_ready_o;
    logic [DATA_W-1:0]       mem_resp_data_i;
    logic [ID_W+1:0]         mem_resp_id_i;
    logic                    mem_resp_last_i;
    logic                    busy_o;
    logic                    id_err_o;
    logic                    timeout_o;
`ifdef SIM_MEM_ARB_PERF_EN
    logic [N_REQ*32-1:0]     perf_grants_o;
`endif

    sim_mem_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .tb_clk(tb_clk), .tb_rstn(tb_rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_id_i(req_id_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_id_o(resp_id_o), .resp_last_o(resp_last_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_id_i(mem_resp_id_i),
        .mem_resp_last_i(mem_resp_last_i),
        .busy_o(busy_o), .id_err_o(id_err_o), .timeout_o(timeout_o)
`ifdef SIM_MEM_ARB_PERF_EN
        , .perf_grants_o(perf_grants_o)
`endif
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: one outstanding transaction described by owner/tag/age.
    bit                m_busy, m_issued, m_err, m_to;
    int unsigned       m_owner, m_last, m_age;
    logic [ADDR_W-1:0] m_addr;
    logic [ID_W-1:0]   m_id;

    // Observations feeding the stimulus side only.
    bit                req_hs_seen, beat_hs_seen;
    logic [ID_W+1:0]   req_tag_seen;
    int unsigned       grant_q[$];

    // Behavioural memory responder state.
    int unsigned       pend_beats, pend_wait;
    logic [ID_W+1:0]   pend_tag;
    bit                presenting, bogus_active;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_err = 0; m_to = 0;
        m_owner = 0; m_last = N_REQ - 1; m_age = 0; m_addr = '0; m_id = '0;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model past the edge.
    task automatic model_cycle();
        int unsigned      w;
        bit               found, match, exp_mrr;
        logic [N_REQ-1:0] exp_rr, exp_rv;
        req_hs_seen  = mem_req_valid_o && mem_req_ready_i;
        req_tag_seen = mem_req_id_o;
        beat_hs_seen = mem_resp_valid_i && mem_resp_ready_o;
        for (int i = 0; i < N_REQ; i++)
            if (req_ready_o[i] && req_valid_i[i]) grant_q.push_back(i);
        if (!tb_rstn) begin
            check("rst_data", resp_data_o, '0);
            check("rst_ctrl", {req_ready_o, resp_valid_o, resp_id_o, resp_last_o, mem_req_valid_o,
                               mem_req_addr_o, mem_req_id_o, mem_resp_ready_o, busy_o, id_err_o,
                               timeout_o}, '0);
            model_reset();
            return;
        end
        found = 0; w = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned c;
            c = (m_last + k) % N_REQ;
            if (!found && req_valid_i[c]) begin found = 1; w = c; end
        end
        match   = m_busy && m_issued && (mem_resp_id_i == {2'(m_owner), m_id});
        exp_rr  = '0;
        if (!m_busy && found) exp_rr[w] = 1'b1;
        exp_rv  = '0;
        if (match && mem_resp_valid_i) exp_rv[m_owner] = 1'b1;
        exp_mrr = match ? resp_ready_i[m_owner] : 1'b1;

        check("req_ready", req_ready_o, exp_rr);
        check("busy", busy_o, m_busy);
        check("mem_req_valid", mem_req_valid_o, m_busy && !m_issued);
        check("resp_valid", resp_valid_o, exp_rv);
        check("mem_resp_ready", mem_resp_ready_o, exp_mrr);
        check("id_err", id_err_o, m_err);
        check("timeout", timeout_o, m_to);
        if (m_busy && !m_issued) begin
            check("mem_req_addr", mem_req_addr_o, m_addr);
            check("mem_req_id", mem_req_id_o, {2'(m_owner), m_id});
        end
        if (exp_rv != 0) begin
            check("resp_data", resp_data_o, mem_resp_data_i);
            check("resp_id", resp_id_o, mem_resp_id_i[ID_W-1:0]);
            check("resp_last", resp_last_o, mem_resp_last_i);
        end

        if (mem_resp_valid_i && !match) m_err = 1;
        if (!m_busy) begin
            if (found) begin
                m_busy = 1; m_issued = 0; m_owner = w; m_age = 0;
                m_addr = req_addr_i[w*ADDR_W +: ADDR_W];
                m_id   = req_id_i[w*ID_W +: ID_W];
            end
        end else if (match && mem_resp_valid_i && resp_ready_i[m_owner] && mem_resp_last_i) begin
            m_busy = 0; m_last = m_owner;
        end else if (m_age == TIMEOUT - 1) begin
            m_to = 1; m_busy = 0; m_last = m_owner;
        end else begin
            m_age++;
            if (!m_issued && mem_req_ready_i) m_issued = 1;
        end
    endtask

    task automatic cyc_start();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic cyc_end();
        @(negedge tb_clk);
        model_cycle();
    endtask

    task automatic clr_inputs();
        req_valid_i = '0; req_addr_i = '0; req_id_i = '0; resp_ready_i = '0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = '0;
        mem_resp_id_i = '0; mem_resp_last_i = 0;
    endtask

    task automatic clr_mem();
        pend_beats = 0; pend_wait = 0; pend_tag = '0; presenting = 0; bogus_active = 0;
    endtask

    task automatic do_reset();
        cyc_start(); tb_rstn = 0; clr_inputs();
        cyc_end();
        cyc_start();
        cyc_end();
        cyc_start(); tb_rstn = 1;
        cyc_end();
    endtask

    task automatic set_req(input int unsigned i, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
        req_valid_i[i] = 1'b1;
        req_addr_i[i*ADDR_W +: ADDR_W] = a;
        req_id_i[i*ID_W +: ID_W] = id;
    endtask

    // Memory behaviour: answers each accepted request after a delay, optionally with stray beats.
    task automatic auto_mem(input bit rnd);
        if (beat_hs_seen && presenting) begin
            presenting = 0;
            if (bogus_active) bogus_active = 0;
            else if (pend_beats > 0) pend_beats--;
        end
        if (req_hs_seen) begin
            pend_tag   = req_tag_seen;
            pend_beats = rnd ? $urandom_range(1, 4) : 1;
            pend_wait  = rnd ? $urandom_range(0, 3) : 0;
            if (rnd && $urandom_range(0, 19) == 0) pend_beats = 0;
        end
        mem_req_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!presenting) begin
            if (pend_beats > 0 && pend_wait > 0) begin
                pend_wait--;
            end else if (pend_beats > 0) begin
                mem_resp_id_i   = pend_tag;
                mem_resp_last_i = (pend_beats == 1);
                mem_resp_data_i = {$urandom, $urandom, $urandom, $urandom};
                presenting      = 1;
            end else if (rnd && $urandom_range(0, 39) == 0) begin
                mem_resp_id_i   = 10'($urandom);
                mem_resp_last_i = 1'($urandom);
                mem_resp_data_i = {$urandom, $urandom, $urandom, $urandom};
                presenting      = 1;
                bogus_active    = 1;
            end
        end
        mem_resp_valid_i = presenting;
    endtask

    task automatic drain(input bit rnd);
        bit ok;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            cyc_start(); req_valid_i = '0; resp_ready_i = '1; auto_mem(rnd);
            cyc_end();
            if (!busy_o && pend_beats == 0 && !presenting) begin ok = 1; break; end
        end
        check("drain_bound", ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish, got running expected done");
        $fatal(1, "time limit");
    end

    initial begin
        bit rdy_pat[8];
        int unsigned beat;
        tb_rstn = 0;
        clr_inputs(); clr_mem(); model_reset();
        do_reset();
        check("reset_busy", busy_o, 0);
        check("reset_req_ready", req_ready_o, 3'b000);

        // 1: single icache request, immediate memory, one last beat.
        cyc_start(); set_req(0, 40'h100, 8'd3); resp_ready_i = '1;
        cyc_end();
        check("t1_req_ready", req_ready_o, 3'b001);
        check("t1_no_early_valid", mem_req_valid_o, 0);
        cyc_start(); req_valid_i = '0; mem_req_ready_i = 1;
        cyc_end();
        check("t1_mem_req_valid", mem_req_valid_o, 1);
        check("t1_mem_req_id", mem_req_id_o, 10'h003);
        check("t1_mem_req_addr", mem_req_addr_o, 40'h100);
        cyc_start(); mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_resp_id_i = 10'h003;
        mem_resp_last_i = 1; mem_resp_data_i = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
        cyc_end();
        check("t1_resp_valid", resp_valid_o, 3'b001);
        check("t1_resp_data", resp_data_o, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
        check("t1_resp_id", resp_id_o, 8'd3);
        cyc_start(); mem_resp_valid_i = 0;
        cyc_end();
        check("t1_busy_after", busy_o, 0);

        // 2: everyone requesting continuously rotates 0,1,2,0,1,2 after reset.
        do_reset(); clr_mem(); grant_q.delete();
        for (int c = 0; c < 200 && grant_q.size() < 6; c++) begin
            cyc_start(); req_valid_i = '1; resp_ready_i = '1; auto_mem(0);
            cyc_end();
        end
        check("t2_grant_count", grant_q.size(), 6);
        check("t2_grant_0", grant_q.size() > 0 ? grant_q[0] : 99, 0);
        check("t2_grant_1", grant_q.size() > 1 ? grant_q[1] : 99, 1);
        check("t2_grant_2", grant_q.size() > 2 ? grant_q[2] : 99, 2);
        check("t2_grant_3", grant_q.size() > 3 ? grant_q[3] : 99, 0);
        check("t2_grant_4", grant_q.size() > 4 ? grant_q[4] : 99, 1);
        check("t2_grant_5", grant_q.size() > 5 ? grant_q[5] : 99, 2);
        drain(0);

        // 3: four-beat burst to requester 1 with two back-pressured cycles.
        cyc_start(); clr_inputs(); set_req(1, 40'h2_0000_0040, 8'h21);
        cyc_end();
        check("t3_req_ready", req_ready_o, 3'b010);
        cyc_start(); req_valid_i = '0; mem_req_ready_i = 1;
        cyc_end();
        check("t3_mem_req_id", mem_req_id_o, 10'h121);
        rdy_pat = '{1, 0, 0, 1, 1, 1, 1, 1};
        beat = 0;
        for (int c = 0; c < 8 && beat < 4; c++) begin
            cyc_start(); mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_resp_id_i = 10'h121;
            mem_resp_last_i = (beat == 3); mem_resp_data_i = 128'(beat + 1) * 128'h0101;
            resp_ready_i = '0; resp_ready_i[1] = rdy_pat[c];
            cyc_end();
            if (!rdy_pat[c]) check("t3_backpressure", mem_resp_ready_o, 0);
            if (resp_valid_o[1] && resp_ready_i[1]) begin
                check("t3_beat_data", resp_data_o, 128'(beat + 1) * 128'h0101);
                beat++;
            end
        end
        check("t3_beats", beat, 4);
        cyc_start(); mem_resp_valid_i = 0;
        cyc_end();
        check("t3_idle", busy_o, 0);

        // 4: wrong-source id is swallowed and flagged; correct id still completes.
        cyc_start(); clr_inputs(); set_req(1, 40'h55, 8'h05); resp_ready_i = '1;
        cyc_end();
        cyc_start(); req_valid_i = '0; mem_req_ready_i = 1;
        cyc_end();
        cyc_start(); mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_resp_id_i = 10'h205;
        mem_resp_last_i = 1;
        cyc_end();
        check("t4_consume", mem_resp_ready_o, 1);
        check("t4_not_forwarded", resp_valid_o, 3'b000);
        check("t4_err_before", id_err_o, 0);
        cyc_start(); mem_resp_id_i = 10'h105;
        cyc_end();
        check("t4_id_err", id_err_o, 1);
        check("t4_forwarded", resp_valid_o, 3'b010);
        cyc_start(); mem_resp_valid_i = 0;
        cyc_end();
        check("t4_idle", busy_o, 0);

        // 5: memory never answers; watchdog fires 16 cycles after issue.
        cyc_start(); clr_inputs(); set_req(2, 40'h77, 8'h07); resp_ready_i = '1;
        cyc_end();
        cyc_start(); req_valid_i = '0; mem_req_ready_i = 1;
        cyc_end();
        check("t5_issue", mem_req_valid_o, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc_start(); mem_req_ready_i = 0;
            cyc_end();
            if (k == 15) begin
                check("t5_no_timeout_yet", timeout_o, 0);
                check("t5_busy_before", busy_o, 1);
            end
        end
        check("t5_timeout", timeout_o, 1);
        check("t5_idle", busy_o, 0);
        cyc_start(); set_req(0, 40'h88, 8'h44);
        cyc_end();
        check("t5_regrant", req_ready_o, 3'b001);

        // 6: asynchronous reset while waiting for the response.
        cyc_start(); req_valid_i = '0; mem_req_ready_i = 1;
        cyc_end();
        cyc_start(); mem_req_ready_i = 0;
        cyc_end();
        check("t6_waiting", busy_o, 1);
        cyc_start(); mem_resp_valid_i = 1; mem_resp_id_i = 10'h044; mem_resp_last_i = 0;
        mem_resp_data_i = 128'h1234;
        #1;
        check("t6_live_resp", resp_valid_o, 3'b001);
        tb_rstn = 0;
        #1;
        check("t6_async_ctrl", {req_ready_o, resp_valid_o, mem_req_valid_o, mem_resp_ready_o,
                                busy_o, id_err_o, timeout_o}, '0);
        check("t6_async_data", resp_data_o, '0);
`ifdef SIM_MEM_ARB_PERF_EN
        check("t6_perf_zero", perf_grants_o, '0);
`endif
        cyc_end();
        cyc_start(); tb_rstn = 1; clr_inputs();
        cyc_end();

        // Randomized traffic against the model.
        clr_mem();
        for (int c = 0; c < 3000; c++) begin
            cyc_start();
            for (int i = 0; i < N_REQ; i++) begin
                req_valid_i[i]  = ($urandom_range(0, 2) == 0);
                resp_ready_i[i] = ($urandom_range(0, 3) != 0);
                req_addr_i[i*ADDR_W +: ADDR_W] = {8'($urandom), $urandom};
                req_id_i[i*ID_W +: ID_W] = 8'($urandom);
            end
            auto_mem(1);
            cyc_end();
        end
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
